spike_event_logger: RTL and testbench

- Downstream consumer of the LIF neuron's spike and membrane state outputs.
- Detects spike onsets and timestamps each one with a free-running cycle counter.
- Buffers each event (timestamp plus the membrane state at onset) in a small FIFO.
- Delivers events over a valid/ready stream to the readout path, keeping drop/overflow statistics when the consumer stalls.

---
 rtl/spike_event_logger.sv | 129 ++++++++++++
 tb/tb_spike_event_logger.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_logger.sv
// Spike onset logger: timestamps rising spikes and buffers {ts, state} in a first-word fall-through FIFO.
// Event visible one edge after the onset; a full FIFO without a pop drops the event and counts it.

module event_fifo #(
  parameter  int W     = 24,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  output logic             push_rdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             pop;
  logic             push;

  assign pop      = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_rdy = (level != LVL_W'(DEPTH)) | pop;
  assign push     = push_vld & push_rdy;
  assign out_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
    end
  end

endmodule

module spike_event_logger #(
  parameter int STATE_W = 8,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      spike,
  input  logic [STATE_W-1:0]        state,
  input  logic                      clear_stats,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W+STATE_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [7:0]                drop_count,
  output logic                      overflow
);

  logic [TS_W-1:0] ts;
  logic            spike_d;
  logic            onset;
  logic            push_rdy;
  logic            drop;

  // spike_d tracks spike even while disabled, so a spike already high at enable is never logged.
  assign onset = spike & ~spike_d & enable;
  assign drop  = onset & ~push_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts         <= '0;
      spike_d    <= 1'b0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      spike_d <= spike;
      if (enable)
        ts <= ts + 1'b1;
      if (clear_stats) begin
        drop_count <= '0;
        overflow   <= 1'b0;
      end else if (drop) begin
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 1'b1;
        overflow <= 1'b1;
      end
    end
  end

  event_fifo #(
    .W     (TS_W + STATE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_vld  (onset),
    .push_dat  ({ts, state}),
    .push_rdy  (push_rdy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger with a cycle scoreboard cross-checking every beat.
module tb_spike_event_logger;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        spike = 1'b0;
  logic [7:0]  state = 8'h00;
  logic        clear_stats = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [23:0] q[$];
  logic [15:0] ts_m = '0;
  logic        sd_m = 1'b0;
  logic [7:0]  dc_m = '0;
  logic        ov_m = 1'b0;

  spike_event_logger #(.STATE_W(8), .TS_W(16), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .spike       (spike),
    .state       (state),
    .clear_stats (clear_stats),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs set; advances one edge and checks against the model.
  task automatic tick();
    logic pop_m, onset_m, drop_m;
    pop_m   = (q.size() != 0) && out_ready;
    onset_m = spike && !sd_m && enable;
    drop_m  = 1'b0;
    if (out_valid && out_ready) pops++;
    if (pop_m) void'(q.pop_front());
    if (onset_m) begin
      if (q.size() < DEPTH) q.push_back({ts_m, state});
      else drop_m = 1'b1;
    end
    if (clear_stats) begin
      dc_m = '0;
      ov_m = 1'b0;
    end else if (drop_m) begin
      if (dc_m != 8'hFF) dc_m++;
      ov_m = 1'b1;
    end
    sd_m = spike;
    if (enable) ts_m++;
    @(posedge clk);
    @(negedge clk);
    check("sb_valid", 32'(out_valid), 32'(q.size() != 0));
    check("sb_level", 32'(fifo_level), 32'(q.size()));
    if (q.size() != 0) check("sb_data", 32'(out_data), 32'(q[0]));
    check("sb_drops", 32'(drop_count), 32'(dc_m));
    check("sb_ovf", 32'(overflow), 32'(ov_m));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    q.delete();
    ts_m = '0;
    sd_m = 1'b0;
    dc_m = '0;
    ov_m = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic onset_pair(input logic [7:0] st);
    spike = 1'b1;
    state = st;
    tick();
    spike = 1'b0;
    tick();
  endtask

  initial begin
    // Single onset at ts = 5
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (5) tick();
    spike = 1'b1;
    state = 8'hC8;
    tick();
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h0005C8);
    check("t1_level", 32'(fifo_level), 32'd1);
    spike = 1'b0;
    tick();
    check("t1_valid_one_cycle", 32'(out_valid), 32'd0);
    check("t1_level_empty", 32'(fifo_level), 32'd0);

    // Held spike yields one event; spike rising while disabled is never logged
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    pops = 0;
    spike = 1'b1;
    state = 8'h11;
    tick();
    check("t2_data", 32'(out_data), 32'h000011);
    repeat (9) tick();
    spike = 1'b0;
    repeat (3) tick();
    check("t2_one_event", 32'(pops), 32'd1);
    pops = 0;
    enable = 1'b0;
    tick();
    spike = 1'b1;
    state = 8'h22;
    repeat (3) tick();
    enable = 1'b1;
    repeat (3) tick();
    check("t2_gated_level", 32'(fifo_level), 32'd0);
    check("t2_gated_events", 32'(pops), 32'd0);
    spike = 1'b0;
    tick();
    spike = 1'b1;
    state = 8'h33;
    tick();
    check("t2_ts_frozen", 32'(out_data), 32'h001133);
    spike = 1'b0;
    tick();

    // Overflow: 11 onsets into 8 entries, drain in order, then clear
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) onset_pair(8'(8'hA0 + i));
    check("t3_level", 32'(fifo_level), 32'd8);
    check("t3_drops", 32'(drop_count), 32'd3);
    check("t3_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t3_drain", 32'(out_data), {8'h00, 16'(2 * i), 8'(8'hA0 + i)});
      tick();
    end
    check("t3_empty", 32'(out_valid), 32'd0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("t3_clr_drops", 32'(drop_count), 32'd0);
    check("t3_clr_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) onset_pair(8'(i));
    spike = 1'b1;
    clear_stats = 1'b1;
    tick();
    spike = 1'b0;
    clear_stats = 1'b0;
    check("t3_clear_wins_drops", 32'(drop_count), 32'd0);
    check("t3_clear_wins_ovf", 32'(overflow), 32'd0);
    tick();
    onset_pair(8'h55);
    check("t3_drop_after_clr", 32'(drop_count), 32'd1);
    check("t3_ovf_after_clr", 32'(overflow), 32'd1);

    // Full with simultaneous pop: no drop, new event last
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) onset_pair(8'(8'hB0 + i));
    check("t4_full", 32'(fifo_level), 32'd8);
    out_ready = 1'b1;
    spike = 1'b1;
    state = 8'hEE;
    tick();
    spike = 1'b0;
    check("t4_level_stays", 32'(fifo_level), 32'd8);
    check("t4_no_drop", 32'(drop_count), 32'd0);
    for (int i = 1; i < 8; i++) begin
      check("t4_drain", 32'(out_data), {8'h00, 16'(2 * i), 8'(8'hB0 + i)});
      tick();
    end
    check("t4_last", 32'(out_data), 32'h0010EE);
    tick();
    check("t4_empty", 32'(out_valid), 32'd0);

    // Random backpressure against the scoreboard
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      spike     = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = 1'($urandom_range(0, 1));
      state     = 8'($urandom);
      tick();
    end
    spike = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    check("t5_drained", 32'(out_valid), 32'd0);

    // Async reset with entries buffered
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) onset_pair(8'(8'hD0 + i));
    check("t6_level4", 32'(fifo_level), 32'd4);
    apply_reset();
    out_ready = 1'b1;
    repeat (3) tick();
    check("t6_no_stale_valid", 32'(out_valid), 32'd0);
    check("t6_no_stale_data", 32'(out_data), 32'd0);

    // Timestamp wrap
    apply_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (65534) tick();
    spike = 1'b1;
    state = 8'hA5;
    tick();
    check("t7_ts_fffe", 32'(out_data), 32'hFFFEA5);
    spike = 1'b0;
    tick();
    spike = 1'b1;
    state = 8'h5A;
    tick();
    check("t7_ts_wrap", 32'(out_data), 32'h00005A);
    spike = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
